lift_row_seq: RTL and testbench

- Sequencer that drives the registered lifting-step engine (ports l_s, r_s, s_s, e_o_s, f_i_s, res_s).
- Runs one full 1-D LeGall 5/3 lifting pass, forward or inverse, in place over one row held in an external single-port row buffer.
- Owns the read/compute/write schedule, boundary mirroring, and predict/update pass ordering.
- Sits between the row-buffer controller and the lifting engine in the wavelet path.

---
 rtl/lift_row_seq.sv | 155 +++++++++++++++
 tb/tb_lift_row_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lift_row_seq.sv
// In-place 1-D LeGall 5/3 lifting sequencer: fetches neighbours and target from a single-port
// row buffer, presents them to the registered lifting engine, and writes the result back.
module lift_row_seq #(
    parameter int W  = 16,
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                fwd,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       mem_addr,
    output logic                mem_rd,
    input  logic [W-1:0]        mem_rdata,
    output logic                mem_we,
    output logic [W-1:0]        mem_wdata,
    output logic signed [W-1:0] l_s,
    output logic signed [W-1:0] r_s,
    output logic signed [W-1:0] s_s,
    output logic                e_o_s,
    output logic                f_i_s,
    input  logic signed [W-1:0] res_s
);

    typedef enum logic [2:0] {IDLE, RD_L, RD_S, RD_R, LATCH, EXEC, WR, FIN} state_t;

    state_t        state_r;
    logic          pass_r;
    logic [AW-1:0] idx_r;
    logic [W-1:0]  l_data_r;
    logic [W-1:0]  s_data_r;

    logic [AW-1:0] last_s;
    logic [AW-1:0] next_idx_s;
    logic [AW-1:0] other_first_s;
    logic [AW-1:0] start_first_s;

    // Symmetric extension: sample 0 mirrors onto 1, sample N-1 mirrors onto N-2.
    function automatic logic [AW-1:0] left_of(input logic [AW-1:0] k);
        if (k == AW'(0)) return AW'(1);
        else             return k - AW'(1);
    endfunction

    function automatic logic [AW-1:0] right_of(input logic [AW-1:0] k);
        if (k == AW'(N-1)) return AW'(N-2);
        else               return k + AW'(1);
    endfunction

    // Index bookkeeping for the current pass and the pass that follows it.
    always_comb begin
        last_s        = e_o_s ? AW'(N-1) : AW'(N-2);
        next_idx_s    = idx_r + AW'(2);
        other_first_s = e_o_s ? AW'(0) : AW'(1);
        start_first_s = fwd ? AW'(1) : AW'(0);
    end

    // Write data is only meaningful while the write strobe is up; the engine result lands that cycle.
    assign mem_wdata = mem_we ? res_s : {W{1'b0}};

    // Row sequencer: six cycles per sample, two passes per row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            pass_r   <= 1'b0;
            idx_r    <= {AW{1'b0}};
            l_data_r <= {W{1'b0}};
            s_data_r <= {W{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_rd   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= {AW{1'b0}};
            l_s      <= {W{1'b0}};
            r_s      <= {W{1'b0}};
            s_s      <= {W{1'b0}};
            e_o_s    <= 1'b0;
            f_i_s    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        f_i_s    <= fwd;
                        e_o_s    <= fwd;
                        pass_r   <= 1'b0;
                        idx_r    <= start_first_s;
                        busy     <= 1'b1;
                        mem_rd   <= 1'b1;
                        mem_addr <= left_of(start_first_s);
                        state_r  <= RD_L;
                    end
                end
                RD_L: begin
                    mem_addr <= idx_r;
                    state_r  <= RD_S;
                end
                RD_S: begin
                    l_data_r <= mem_rdata;
                    mem_addr <= right_of(idx_r);
                    state_r  <= RD_R;
                end
                RD_R: begin
                    s_data_r <= mem_rdata;
                    mem_rd   <= 1'b0;
                    state_r  <= LATCH;
                end
                LATCH: begin
                    l_s     <= $signed(l_data_r);
                    s_s     <= $signed(s_data_r);
                    r_s     <= $signed(mem_rdata);
                    state_r <= EXEC;
                end
                EXEC: begin
                    mem_we   <= 1'b1;
                    mem_addr <= idx_r;
                    state_r  <= WR;
                end
                WR: begin
                    mem_we <= 1'b0;
                    if (idx_r != last_s) begin
                        idx_r    <= next_idx_s;
                        mem_rd   <= 1'b1;
                        mem_addr <= left_of(next_idx_s);
                        state_r  <= RD_L;
                    end else if (!pass_r) begin
                        pass_r   <= 1'b1;
                        e_o_s    <= ~e_o_s;
                        idx_r    <= other_first_s;
                        mem_rd   <= 1'b1;
                        mem_addr <= left_of(other_first_s);
                        state_r  <= RD_L;
                    end else begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= FIN;
                    end
                end
                FIN: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    mem_rd  <= 1'b0;
                    mem_we  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lift_row_seq.sv
// Scoreboard bench for lift_row_seq with a behavioural row buffer and lifting engine.
module tb_lift_row_seq;

    localparam int W  = 16;
    localparam int N  = 8;
    localparam int AW = 3;

    typedef logic signed [W-1:0] row_t [N];
    typedef struct {
        logic [AW-1:0]       addr;
        logic signed [W-1:0] data;
        logic signed [W-1:0] l;
        logic signed [W-1:0] r;
        logic signed [W-1:0] s;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                fwd = 1'b0;
    logic                busy, done, mem_rd, mem_we, e_o_s, f_i_s;
    logic [AW-1:0]       mem_addr;
    logic [W-1:0]        mem_rdata;
    logic [W-1:0]        mem_wdata;
    logic signed [W-1:0] l_s, r_s, s_s, res_s;

    logic signed [W-1:0] mem [N];
    row_t                load_vals;
    logic                load_req = 1'b0;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    int   busy_cyc = 0;

    lift_row_seq #(.W(W), .N(N), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .fwd(fwd),
        .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata),
        .l_s(l_s), .r_s(r_s), .s_s(s_s), .e_o_s(e_o_s), .f_i_s(f_i_s),
        .res_s(res_s)
    );

    always #5 clk = ~clk;

    // LeGall 5/3 lifting step, W-bit wrap.
    function automatic logic signed [W-1:0] eng(input logic eo, input logic fi,
                                                input logic signed [W-1:0] l,
                                                input logic signed [W-1:0] r,
                                                input logic signed [W-1:0] s);
        logic signed [W-1:0] sum;
        if (eo) begin
            sum = l + r;
            return fi ? s - (sum >>> 1) : s + (sum >>> 1);
        end
        sum = l + r + 16'sd2;
        return fi ? s + (sum >>> 2) : s - (sum >>> 2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) res_s <= '0;
        else        res_s <= eng(e_o_s, f_i_s, l_s, r_s, s_s);
    end

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < N; i++) mem[i] <= load_vals[i];
        end else begin
            if (mem_rd) mem_rdata <= mem[mem_addr];
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end
    end

    // Monitor: pops one expectation per write, checks row length on every done.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cyc = 0;
        end else begin
            if (busy) busy_cyc++;
            if (mem_rd && mem_we) begin
                checks++; errors++;
                $display("FAIL rd_we_overlap: both strobes high at addr=%0d", mem_addr);
            end
            if (mem_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: addr=%0d data=%0d, none required", mem_addr, $signed(mem_wdata));
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mem_addr !== mon_e.addr || $signed(mem_wdata) !== mon_e.data ||
                        l_s !== mon_e.l || r_s !== mon_e.r || s_s !== mon_e.s) begin
                        errors++;
                        $display("FAIL write: got addr=%0d data=%0d l=%0d r=%0d s=%0d, want addr=%0d data=%0d l=%0d r=%0d s=%0d",
                                 mem_addr, $signed(mem_wdata), l_s, r_s, s_s,
                                 mon_e.addr, mon_e.data, mon_e.l, mon_e.r, mon_e.s);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                checks++;
                if (busy_cyc != 6*N) begin
                    errors++;
                    $display("FAIL busy_len: got %0d cycles, want %0d", busy_cyc, 6*N);
                end
                busy_cyc = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic build_expect(input row_t v, input logic f);
        row_t x;
        logic eo;
        exp_t e;
        int   lf, rt;
        x = v;
        for (int p = 0; p < 2; p++) begin
            eo = (p == 0) ? f : ~f;
            for (int k = (eo ? 1 : 0); k < N; k += 2) begin
                lf = (k == 0) ? 1 : k - 1;
                rt = (k == N-1) ? N-2 : k + 1;
                e.addr = AW'(k);
                e.l = x[lf];
                e.r = x[rt];
                e.s = x[k];
                e.data = eng(eo, f, e.l, e.r, e.s);
                x[k] = e.data;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic load_row(input row_t v);
        @(negedge clk);
        load_vals = v;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic kick(input logic f);
        start = 1'b1;
        fwd = f;
        @(negedge clk);
        start = 1'b0;
        fwd = ~f;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("f_i_latched", {31'd0, f_i_s}, {31'd0, f});
    endtask

    task automatic wait_done(input int d0, input string name);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_done"}, done_cnt, d0 + 1);
        chk({name, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    task automatic check_buf(input row_t want, input string name);
        #1;
        for (int i = 0; i < N; i++)
            chk($sformatf("%s_buf[%0d]", name, i), {{16{mem[i][W-1]}}, mem[i]}, {{16{want[i][W-1]}}, want[i]});
    endtask

    task automatic run_row(input row_t v, input logic f, input row_t want, input string name);
        int d0;
        load_row(v);
        build_expect(v, f);
        d0 = done_cnt;
        kick(f);
        wait_done(d0, name);
        check_buf(want, name);
    endtask

    initial begin
        row_t ramp, ramp_f, cst, cst_f, alt, alt_f;
        int   d0;
        ramp   = '{16'sd0, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7};
        ramp_f = '{16'sd0, 16'sd0, 16'sd2, 16'sd0, 16'sd4, 16'sd0, 16'sd6, 16'sd1};
        cst    = '{16'sd100, 16'sd100, 16'sd100, 16'sd100, 16'sd100, 16'sd100, 16'sd100, 16'sd100};
        cst_f  = '{16'sd100, 16'sd0, 16'sd100, 16'sd0, 16'sd100, 16'sd0, 16'sd100, 16'sd0};
        alt    = '{-16'sd4, 16'sd10, -16'sd4, 16'sd10, -16'sd4, 16'sd10, -16'sd4, 16'sd10};
        alt_f  = '{16'sd3, 16'sd14, 16'sd3, 16'sd14, 16'sd3, 16'sd14, 16'sd3, 16'sd14};

        repeat (2) @(negedge clk);
        chk("reset_ctrl", {23'd0, busy, done, mem_rd, mem_we, e_o_s, f_i_s, mem_addr}, 32'd0);
        chk("reset_data", {16'd0, l_s | r_s | s_s | $signed(mem_wdata)}, 32'd0);
        rst_n = 1'b1;

        run_row(ramp, 1'b1, ramp_f, "fwd_ramp");
        run_row(ramp_f, 1'b0, ramp, "inv_ramp");
        run_row(alt, 1'b1, alt_f, "fwd_alt");

        // Extra starts mid-row and during the done cycle; then a start right after done.
        load_row(cst);
        build_expect(cst, 1'b1);
        d0 = done_cnt;
        kick(1'b1);
        for (int c = 1; c <= 48; c++) begin
            @(negedge clk);
            if (c == 48) chk("done_at_48", {31'd0, done}, 32'd1);
            start = (c == 9 || c == 29 || c == 48);
        end
        @(negedge clk);
        start = 1'b0;
        chk("single_done", done_cnt, d0 + 1);
        chk("start_in_fin_ignored", {31'd0, busy}, 32'd0);
        check_buf(cst_f, "fwd_const");
        build_expect(cst_f, 1'b0);
        d0 = done_cnt;
        kick(1'b0);
        wait_done(d0, "inv_const");
        check_buf(cst, "inv_const");

        // Reset in the middle of a row.
        load_row(ramp);
        build_expect(ramp, 1'b1);
        d0 = done_cnt;
        kick(1'b1);
        repeat (19) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {23'd0, busy, done, mem_rd, mem_we, e_o_s, f_i_s, mem_addr}, 32'd0);
        chk("midrst_data", {16'd0, l_s | r_s | s_s | $signed(mem_wdata)}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_done", done_cnt, d0);
        run_row(ramp, 1'b1, ramp_f, "post_reset_fwd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
